// File: rtl/stack_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : stack_ctrl_if
// Description : Command/response handshake bundle for the stack sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stack_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic              cmd_sel;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/stack_ctrl.sv
//------------------------------------------------------------------------------
// Module      : stack_ctrl
// Description : Sequences PUSH/POP/PEEK/DUP/MOVE/SWAP onto two shared LIFO stacks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stack_ctrl #(
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    stack_ctrl_if.slave            ctl,
    output logic                   stack_select,
    output logic                   push,
    output logic                   pop,
    output logic [DATA_W-1:0]      stk_data_in,
    input  wire logic [DATA_W-1:0] stk_rd_data,
    input  wire logic              empty0,
    input  wire logic              full0,
    input  wire logic              empty1,
    input  wire logic              full1
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_SEL   = 4'd1;
    localparam logic [3:0] S_CHK   = 4'd2;
    localparam logic [3:0] S_POP1  = 4'd3;
    localparam logic [3:0] S_CHK2  = 4'd4;
    localparam logic [3:0] S_POP2  = 4'd5;
    localparam logic [3:0] S_PUSH1 = 4'd6;
    localparam logic [3:0] S_PUSH2 = 4'd7;
    localparam logic [3:0] S_RESP  = 4'd8;

    localparam logic [2:0] C_OP_NOP  = 3'd0;
    localparam logic [2:0] C_OP_PUSH = 3'd1;
    localparam logic [2:0] C_OP_POP  = 3'd2;
    localparam logic [2:0] C_OP_PEEK = 3'd3;
    localparam logic [2:0] C_OP_DUP  = 3'd4;
    localparam logic [2:0] C_OP_MOVE = 3'd5;
    localparam logic [2:0] C_OP_SWAP = 3'd6;
    localparam logic [2:0] C_OP_RSV  = 3'd7;

    logic [3:0]        r_state;
    logic [2:0]        r_op;
    logic              r_cmd_sel;
    logic [DATA_W-1:0] r_cmd_data;
    logic [DATA_W-1:0] r_top;
    logic [DATA_W-1:0] r_second;
    logic              r_swap_err;
    logic              r_sel;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic w_accept;
    logic w_empty_sel;
    logic w_full_sel;
    logic w_full_dst;
    logic w_under;
    logic w_over;

    assign w_accept    = ctl.cmd_valid & ctl.cmd_ready;
    assign w_empty_sel = r_sel ? empty1 : empty0;
    assign w_full_sel  = r_sel ? full1 : full0;
    assign w_full_dst  = r_cmd_sel ? full0 : full1;
    assign w_under     = w_empty_sel & ((r_op == C_OP_POP) | (r_op == C_OP_PEEK) |
                                        (r_op == C_OP_DUP) | (r_op == C_OP_MOVE) |
                                        (r_op == C_OP_SWAP));
    assign w_over      = (w_full_sel & ((r_op == C_OP_PUSH) | (r_op == C_OP_DUP))) |
                         ((r_op == C_OP_MOVE) & w_full_dst);

    // Every output is forced to its reset value as soon as rst_n drops.
    assign ctl.cmd_ready = rst_n & (r_state == S_IDLE);
    assign ctl.rsp_valid = rst_n & (r_state == S_RESP);
    assign ctl.rsp_data  = rst_n ? r_rsp_data : '0;
    assign ctl.rsp_err   = rst_n & r_rsp_err;
    assign stack_select  = rst_n & r_sel;
    assign push          = rst_n & ((r_state == S_PUSH1) | (r_state == S_PUSH2));
    assign pop           = rst_n & ((r_state == S_POP1) | (r_state == S_POP2));

    always_comb begin
        stk_data_in = '0;
        if (rst_n) begin
            if (r_state == S_PUSH1) begin
                stk_data_in = (r_op == C_OP_PUSH) ? r_cmd_data : r_top;
            end else if (r_state == S_PUSH2) begin
                stk_data_in = r_second;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= C_OP_NOP;
            r_cmd_sel  <= 1'b0;
            r_cmd_data <= '0;
            r_top      <= '0;
            r_second   <= '0;
            r_swap_err <= 1'b0;
            r_sel      <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= ctl.cmd_op;
                        r_cmd_sel  <= ctl.cmd_sel;
                        r_cmd_data <= ctl.cmd_data;
                        r_swap_err <= 1'b0;
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b0;
                        if (ctl.cmd_op == C_OP_NOP) begin
                            r_state <= S_RESP;
                        end else if (ctl.cmd_op == C_OP_RSV) begin
                            r_rsp_err <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            r_sel   <= ctl.cmd_sel;
                            r_state <= S_SEL;
                        end
                    end
                end
                S_SEL: r_state <= S_CHK;
                S_CHK: begin
                    r_top <= stk_rd_data;
                    if (w_under | w_over) begin
                        r_rsp_err <= 1'b1;
                        r_state   <= S_RESP;
                    end else if (r_op == C_OP_PEEK) begin
                        r_rsp_data <= stk_rd_data;
                        r_state    <= S_RESP;
                    end else if ((r_op == C_OP_PUSH) | (r_op == C_OP_DUP)) begin
                        r_state <= S_PUSH1;
                    end else begin
                        r_state <= S_POP1;
                    end
                end
                S_POP1: begin
                    if (r_op == C_OP_POP) begin
                        r_rsp_data <= r_top;
                        r_state    <= S_RESP;
                    end else if (r_op == C_OP_MOVE) begin
                        r_sel   <= ~r_sel;
                        r_state <= S_PUSH1;
                    end else begin
                        r_state <= S_CHK2;
                    end
                end
                S_CHK2: begin
                    // A failed SWAP still re-pushes top so the stack is left intact.
                    r_second <= stk_rd_data;
                    if (w_empty_sel) begin
                        r_swap_err <= 1'b1;
                        r_state    <= S_PUSH1;
                    end else begin
                        r_state <= S_POP2;
                    end
                end
                S_POP2: r_state <= S_PUSH1;
                S_PUSH1: begin
                    if ((r_op == C_OP_SWAP) & ~r_swap_err) begin
                        r_state <= S_PUSH2;
                    end else begin
                        if (r_swap_err) begin
                            r_rsp_err <= 1'b1;
                        end else if (r_op != C_OP_PUSH) begin
                            r_rsp_data <= r_top;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_PUSH2: begin
                    r_rsp_data <= r_second;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (ctl.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_stack_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_stack_ctrl
// Description : Directed scoreboard bench for stack_ctrl with two 16-deep stack models.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stack_ctrl;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, PEEK = 3'd3;
    localparam logic [2:0] DUP = 3'd4, MOVE = 3'd5, SWAP = 3'd6, RSV = 3'd7;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         lat;
    } exp_t;

    typedef struct {
        int         cyc;
        bit         is_push;
        bit         sel;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stack_select, push, pop;
    logic [7:0] stk_data_in;
    logic [7:0] rd = 8'h00;
    logic       empty0, full0, empty1, full1;

    stack_ctrl_if #(.DATA_W(8)) bus ();

    stack_ctrl #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctl          (bus),
        .stack_select (stack_select),
        .push         (push),
        .pop          (pop),
        .stk_data_in  (stk_data_in),
        .stk_rd_data  (rd),
        .empty0       (empty0),
        .full0        (full0),
        .empty1       (empty1),
        .full1        (full1)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int overlap = 0;
    int idle_data = 0;
    int stab = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    ev_t  ev_q[$];

    task automatic chk(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Two 16-deep stacks; read data is registered and reflects the top after this edge.
    logic [7:0] mem [2][16];
    int sp [2] = '{0, 0};
    assign empty0 = (sp[0] == 0);
    assign full0  = (sp[0] == 16);
    assign empty1 = (sp[1] == 0);
    assign full1  = (sp[1] == 16);

    always @(posedge clk) begin : stk_model
        int s, n;
        if (!rst_n) begin
            sp[0] <= 0;
            sp[1] <= 0;
            rd    <= 8'h00;
        end else begin
            s = stack_select ? 1 : 0;
            n = sp[s];
            if (push && n < 16) begin
                mem[s][n] <= stk_data_in;
                n = n + 1;
                rd <= stk_data_in;
            end else begin
                if (pop && n > 0) n = n - 1;
                rd <= (n > 0) ? mem[s][n-1] : 8'h00;
            end
            sp[s] <= n;
        end
    end

    logic       prev_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_e = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        int   a;
        cyc++;
        if (!rst_n) begin
            acc_q.delete();
            prev_v = 1'b0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
            if (push || pop) ev_q.push_back('{cyc, push, stack_select, stk_data_in});
            if (push && pop) overlap++;
            if (!push && !pop && stk_data_in != 8'h00) idle_data++;
            if (bus.rsp_valid && !prev_v) begin
                a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", int'(bus.rsp_data), int'(e.d));
                    chk("rsp_err", int'(bus.rsp_err), int'(e.e));
                    chk("rsp_latency", cyc - a, e.lat);
                end
                hold_d = bus.rsp_data;
                hold_e = bus.rsp_err;
            end else if (bus.rsp_valid && (bus.rsp_data != hold_d || bus.rsp_err != hold_e)) begin
                stab++;
            end
            prev_v = bus.rsp_valid;
        end
    end

    task automatic issue(input logic [2:0] op, input logic sel, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee, input int lat,
                         input int stall, input bit wait_rsp);
        bit acc = 0;
        bit done = 0;
        if (stall > 0) bus.rsp_ready = 1'b0;
        bus.cmd_op    = op;
        bus.cmd_sel   = sel;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = 1;
                if (wait_rsp) exp_q.push_back('{ed, ee, lat});
            end
        end
        if (!acc) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        if (!wait_rsp || !acc) return;
        if (stall > 0) begin
            for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("cmd_ready_stalled", int'(bus.cmd_ready), 0);
            end
            @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) done = 1;
        end
        if (!done) chk("rsp_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic sel, input logic [7:0] d,
                       input logic [7:0] ed, input logic ee, input int lat);
        issue(op, sel, d, ed, ee, lat, 0, 1'b1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", int'(bus.cmd_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_rsp_err", int'(bus.rsp_err), 0);
        chk("rst_stack_select", int'(stack_select), 0);
        chk("rst_push", int'(push), 0);
        chk("rst_pop", int'(pop), 0);
        chk("rst_stk_data_in", int'(stk_data_in), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        int n0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_sel   = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;

        n0 = ev_q.size();
        run(PUSH, 1'b0, 8'h5A, 8'h00, 1'b0, 4);
        chk("push_strobe_count", ev_q.size() - n0, 1);
        chk("push_strobe_kind", int'(ev_q[$].is_push), 1);
        run(PEEK, 1'b0, 8'h00, 8'h5A, 1'b0, 3);
        n0 = ev_q.size();
        run(POP, 1'b1, 8'h00, 8'h00, 1'b1, 3);
        chk("underflow_no_strobe", ev_q.size() - n0, 0);
        run(POP, 1'b0, 8'h00, 8'h5A, 1'b0, 4);
        run(NOP, 1'b0, 8'h00, 8'h00, 1'b0, 1);
        run(RSV, 1'b1, 8'h00, 8'h00, 1'b1, 1);

        for (int i = 0; i < 16; i++) run(PUSH, 1'b0, 8'h80 + 8'(i), 8'h00, 1'b0, 4);
        run(DUP, 1'b0, 8'h00, 8'h00, 1'b1, 3);
        run(PUSH, 1'b0, 8'hEE, 8'h00, 1'b1, 3);
        for (int i = 15; i >= 0; i--) run(POP, 1'b0, 8'h00, 8'h80 + 8'(i), 1'b0, 4);

        run(PUSH, 1'b0, 8'h11, 8'h00, 1'b0, 4);
        run(MOVE, 1'b0, 8'h00, 8'h11, 1'b0, 5);
        chk("move_pop_kind", int'(ev_q[$-1].is_push), 0);
        chk("move_pop_sel", int'(ev_q[$-1].sel), 0);
        chk("move_push_kind", int'(ev_q[$].is_push), 1);
        chk("move_push_sel", int'(ev_q[$].sel), 1);
        chk("move_push_data", int'(ev_q[$].d), 8'h11);
        chk("move_consecutive", ev_q[$].cyc - ev_q[$-1].cyc, 1);
        run(PEEK, 1'b0, 8'h00, 8'h00, 1'b1, 3);
        run(POP, 1'b1, 8'h00, 8'h11, 1'b0, 4);

        run(PUSH, 1'b1, 8'h22, 8'h00, 1'b0, 4);
        run(DUP, 1'b1, 8'h00, 8'h22, 1'b0, 4);
        run(POP, 1'b1, 8'h00, 8'h22, 1'b0, 4);
        run(POP, 1'b1, 8'h00, 8'h22, 1'b0, 4);

        run(PUSH, 1'b0, 8'h01, 8'h00, 1'b0, 4);
        run(PUSH, 1'b0, 8'h02, 8'h00, 1'b0, 4);
        run(SWAP, 1'b0, 8'h00, 8'h01, 1'b0, 8);
        run(POP, 1'b0, 8'h00, 8'h01, 1'b0, 4);
        run(POP, 1'b0, 8'h00, 8'h02, 1'b0, 4);

        run(PUSH, 1'b0, 8'h33, 8'h00, 1'b0, 4);
        run(SWAP, 1'b0, 8'h00, 8'h00, 1'b1, 6);
        run(PEEK, 1'b0, 8'h00, 8'h33, 1'b0, 3);
        run(POP, 1'b0, 8'h00, 8'h33, 1'b0, 4);

        issue(PUSH, 1'b1, 8'h44, 8'h00, 1'b0, 4, 5, 1'b1);
        run(POP, 1'b1, 8'h00, 8'h44, 1'b0, 4);

        // Abandon a SWAP mid-sequence; no response may follow.
        run(PUSH, 1'b0, 8'h05, 8'h00, 1'b0, 4);
        run(PUSH, 1'b0, 8'h06, 8'h00, 1'b0, 4);
        issue(SWAP, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        run(PEEK, 1'b0, 8'h00, 8'h00, 1'b1, 3);

        chk("pending_responses", exp_q.size(), 0);
        chk("strobe_overlap", overlap, 0);
        chk("data_in_outside_push", idle_data, 0);
        chk("rsp_stable_under_stall", stab, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/stack_ctrl.md
# stack_ctrl

Command sequencer sitting in front of the two 8-bit LIFO stack instances (select addresses 0 and 1) of the dual-deque datapath. It accepts one command at a time over a valid/ready handshake and drives the shared `stack_select`/`push`/`pop`/`data_in` bus as a fixed multi-cycle sequence. It supports simple and compound operations (PEEK, DUP, MOVE, SWAP) and returns one response per command with data and an error flag.

## Interface
- `DATA_W`, default 8: data width; must equal the stack word width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low; shared with both stacks.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE with `rst_n` high.
- `cmd_op`  in  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 PEEK, 4 DUP, 5 MOVE, 6 SWAP, 7 reserved.
- `cmd_sel`  in  1  target stack (MOVE: source; destination is `~cmd_sel`).
- `cmd_data`  in  DATA_W  PUSH operand.
- `rsp_valid`  out  1  response held until accepted.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_data`  out  DATA_W  result; 0 on error and for PUSH/NOP.
- `rsp_err`  out  1  underflow, overflow or invalid opcode.
- `stack_select`  out  1  to both stacks.
- `push`, `pop`  out  1 each  single-cycle strobes to both stacks.
- `stk_data_in`  out  DATA_W  write data to both stacks.
- `stk_rd_data`  in  DATA_W  OR of both stacks' `data_out`.
- `empty0`, `full0`, `empty1`, `full1`  in  1 each  stack flags.

## Operation
- `cmd_op`, `cmd_sel` and `cmd_data` are latched on the accept cycle (`cmd_valid & cmd_ready`).
- States: IDLE, SEL, CHK, POP1, CHK2, POP2, PUSH1, PUSH2, RESP.
- `stack_select`, `push`, `pop` and `stk_data_in` are Moore outputs of registered state.
- `stack_select` is a register. It is loaded with `cmd_sel` on entry to SEL and holds its value in IDLE and RESP.
- SEL lasts one cycle, because the stack's read output is valid only one cycle after it is selected.
- CHK captures `stk_rd_data` into `top` and checks the flags:
  - Underflow: selected stack empty for POP, PEEK, DUP, MOVE or SWAP.
  - Overflow: selected stack full for PUSH or DUP, or the destination stack full for MOVE.
  - On error, go to RESP with `rsp_err`=1 and no stack write.
- Command sequences after CHK:
  - PEEK: RESP.
  - POP: POP1, then RESP.
  - PUSH: PUSH1 (`stk_data_in`=`cmd_data`), then RESP.
  - DUP: PUSH1 (`top`), then RESP.
  - MOVE: POP1 on the source, then PUSH1 with `stack_select`=~`cmd_sel` and `stk_data_in`=`top`, then RESP.
  - SWAP: POP1, then CHK2 (capture `second`; error if now empty), POP2, PUSH1 (`top`), PUSH2 (`second`), RESP.
- SWAP error path: from CHK2, PUSH1 (`top`, restoring the stack), then RESP with `rsp_err`=1. Net stack state is unchanged.
- NOP and opcode 7 go IDLE to RESP directly with no stack access. NOP returns `rsp_err`=0; opcode 7 returns `rsp_err`=1.
- `rsp_data` per command:
  - POP, PEEK, DUP, MOVE: `top`.
  - SWAP: the new top (`second`).
  - PUSH, NOP, and any error: 0.
- RESP holds `rsp_valid`, `rsp_data` and `rsp_err` stable until `rsp_ready`, then goes to IDLE. There is no new accept in that same cycle.

## Timing
- Accept cycle is c0. `rsp_valid` first rises at:
  - c1: NOP and opcode 7.
  - c3: PEEK, and any CHK error.
  - c4: POP, PUSH, DUP.
  - c5: MOVE.
  - c6: SWAP with depth 1.
  - c8: SWAP.
- Each strobe is high for exactly one cycle per state, and never together with the other strobe.
- Outside POP1, POP2, PUSH1 and PUSH2, `push`=`pop`=0 and `stk_data_in`=0.
- Reset values, all held while `rst_n` is low: state IDLE, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `stack_select`=0, `push`=0, `pop`=0, `stk_data_in`=0.
- Reset mid-operation abandons the command with no further strobes and no response. The stacks reset in the same cycle.
- `full` flags are select-independent and are sampled in CHK. `empty` flags are sampled in CHK and CHK2.

## Test plan
- Reset, then PUSH sel0 0x5A, then PEEK sel0 -> first response at c4 with err=0; PEEK returns 0x5A at c3 after its accept; `push` high exactly one cycle.
- POP sel1 on an empty stack -> rsp at c3, err=1, data=0, no `pop` strobe.
- Push 16 words to sel0, then DUP sel0 -> err=1 (overflow); a further PUSH also returns err=1.
- PUSH sel0 0x11, then MOVE sel0 -> data=0x11 at c5; stack0 empty, stack1 top=0x11; `pop` on select 0 then `push` on select 1 in consecutive cycles.
- PUSH 0x01, PUSH 0x02, SWAP -> data=0x01 at c8; pops return 0x01 then 0x02.
- SWAP with depth 1 (top 0x33) -> err=1 at c6; PEEK returns 0x33.
- Hold `rsp_ready` low for 5 cycles -> response stable and `cmd_ready`=0; reset asserted during a SWAP -> no response, all outputs at reset values.
